// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit type codes, filereg word width and tonet FSM encoding
package noc_pkg;

  localparam int unsigned FILEREG_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    FLIT_TYPE_HEADER      = 2'd0,
    FLIT_TYPE_BODY        = 2'd1,
    FLIT_TYPE_TAIL        = 2'd2,
    FLIT_TYPE_HEADER_TAIL = 2'd3
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_MSB = 2'd1,
    ST_SEND_LSB = 2'd2
  } tonet_state_e;

endpackage

// File: rtl/network_signal_packer.sv
// rtl/network_signal_packer.sv - packs flit, flit type, broadcast and vn id into one NI data word
module network_signal_packer #(
  parameter int unsigned NetworkIfFlitWidth             = 64,
  parameter int unsigned NetworkIfFlitTypeWidth         = 2,
  parameter int unsigned NetworkIfBroadcastWidth        = 1,
  parameter int unsigned NetworkIfVirtualNetworkIdWidth = 2,
  localparam int unsigned NetworkIfDataWidth = NetworkIfFlitWidth + NetworkIfFlitTypeWidth +
                                               NetworkIfBroadcastWidth + NetworkIfVirtualNetworkIdWidth
) (
  input  logic [NetworkIfFlitWidth-1:0]             flit,
  input  logic [NetworkIfFlitTypeWidth-1:0]         flit_type,
  input  logic [NetworkIfBroadcastWidth-1:0]        broadcast,
  input  logic [NetworkIfVirtualNetworkIdWidth-1:0] vn_id,
  output logic [NetworkIfDataWidth-1:0]             network_data
);

  assign network_data = {flit, flit_type, broadcast, vn_id};

endmodule

// File: rtl/filereg_tonet.sv
// rtl/filereg_tonet.sv - filereg response (one 64-bit beat) to 2-flit NoC packet, MSB word first
// FILEREG_TONET_SKID_EN selects a 2-entry response FIFO with a flop-only tready.
module filereg_tonet #(
  parameter int unsigned FileRegIfDataWidth             = 64,
  parameter int unsigned NetworkIfFlitWidth             = 64,
  parameter int unsigned NetworkIfFlitTypeWidth         = 2,
  parameter int unsigned NetworkIfBroadcastWidth        = 1,
  parameter int unsigned NetworkIfVirtualNetworkIdWidth = 2,
  parameter int unsigned NetworkIfDestIdWidth           = 8,
  localparam int unsigned NetworkIfDataWidth = NetworkIfFlitWidth + NetworkIfFlitTypeWidth +
                                               NetworkIfBroadcastWidth + NetworkIfVirtualNetworkIdWidth
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      filereg_s_tvalid_i,
  output logic                                      filereg_s_tready_o,
  input  logic [FileRegIfDataWidth-1:0]             filereg_s_tdata_i,
  input  logic                                      filereg_s_tlast_i,
  input  logic [NetworkIfDestIdWidth-1:0]           dst_id_i,
  input  logic [NetworkIfVirtualNetworkIdWidth-1:0] vn_id_i,
  output logic                                      network_valid_o,
  input  logic                                      network_ready_i,
  output logic [NetworkIfDataWidth-1:0]             network_data_o
);
  import noc_pkg::*;

  localparam int unsigned WordWidth  = FILEREG_WORD_WIDTH;
  localparam int unsigned VnW        = NetworkIfVirtualNetworkIdWidth;
  localparam int unsigned EntryWidth = FileRegIfDataWidth + NetworkIfDestIdWidth + VnW;

  if (FileRegIfDataWidth != 2 * WordWidth) begin : g_data_width_check
    $error("filereg_tonet: FileRegIfDataWidth must be 64");
  end
  if (NetworkIfFlitWidth < WordWidth + NetworkIfDestIdWidth) begin : g_flit_width_check
    $error("filereg_tonet: NetworkIfFlitWidth too narrow for word plus destination id");
  end

  tonet_state_e            state_q;
  flit_type_e              type_q;
  logic                    valid_q;
  logic [WordWidth-1:0]    word_q;
  logic [EntryWidth-1:0]   head_q, entry_in, next_entry;
  logic [1:0]              count_q;
  logic                    net_hs, pop, push, next_avail;
  logic                    unused_tlast;

  // head_q always holds the response whose packet is on (or about to be on) the network
  assign entry_in     = {filereg_s_tdata_i, dst_id_i, vn_id_i};
  assign net_hs       = valid_q & network_ready_i;
  assign pop          = net_hs && (state_q == ST_SEND_LSB);
  assign push         = filereg_s_tvalid_i & filereg_s_tready_o;
  assign unused_tlast = filereg_s_tlast_i;

`ifdef FILEREG_TONET_SKID_EN
  logic [EntryWidth-1:0] tail_q;

  assign filereg_s_tready_o = (count_q != 2'd2);
  assign next_avail         = (count_q == 2'd2) || push;
  assign next_entry         = (count_q == 2'd2) ? tail_q : entry_in;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (pop) head_q <= next_entry;
      else if (push && count_q == 2'd0) head_q <= entry_in;
      if (push && !pop && count_q == 2'd1) tail_q <= entry_in;
    end
  end
`else
  // tready follows network_ready_i in SEND_LSB so the register refills as the tail leaves
  assign filereg_s_tready_o = (count_q == 2'd0) || pop;
  assign next_avail         = push;
  assign next_entry         = entry_in;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) head_q <= '0;
    else if (push) head_q <= entry_in;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= 2'd0;
    else count_q <= count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      type_q  <= FLIT_TYPE_HEADER;
      word_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (push) begin
          state_q <= ST_SEND_MSB;
          valid_q <= 1'b1;
          type_q  <= FLIT_TYPE_HEADER;
          word_q  <= entry_in[EntryWidth-1 -: WordWidth];
        end
        ST_SEND_MSB: if (net_hs) begin
          state_q <= ST_SEND_LSB;
          type_q  <= FLIT_TYPE_TAIL;
          word_q  <= head_q[EntryWidth-WordWidth-1 -: WordWidth];
        end
        ST_SEND_LSB: if (net_hs) begin
          if (next_avail) begin
            state_q <= ST_SEND_MSB;
            type_q  <= FLIT_TYPE_HEADER;
            word_q  <= next_entry[EntryWidth-1 -: WordWidth];
          end else begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  logic [NetworkIfFlitWidth-1:0] flit;

  always_comb begin
    flit = '0;
    flit[WordWidth-1:0] = word_q;
    flit[WordWidth +: NetworkIfDestIdWidth] = head_q[VnW +: NetworkIfDestIdWidth];
  end

  assign network_valid_o = valid_q;

  network_signal_packer #(
    .NetworkIfFlitWidth            (NetworkIfFlitWidth),
    .NetworkIfFlitTypeWidth        (NetworkIfFlitTypeWidth),
    .NetworkIfBroadcastWidth       (NetworkIfBroadcastWidth),
    .NetworkIfVirtualNetworkIdWidth(VnW)
  ) u_packer (
    .flit        (flit),
    .flit_type   (NetworkIfFlitTypeWidth'(type_q)),
    .broadcast   ('0),
    .vn_id       (head_q[VnW-1:0]),
    .network_data(network_data_o)
  );

endmodule
